key_event_decoder: RTL and testbench

- Sits directly downstream of the key debouncer in the car control path.
- Consumes one debounced, active-low key level (idle high).
- Classifies each key gesture as short press, long press (with auto-repeat while held) or double click.
- Emits single-cycle event pulses to the command/mode logic.

---
 rtl/key_evt_pkg.sv | 18 +
 rtl/key_edge_det.sv | 26 ++
 rtl/key_event_decoder.sv | 125 ++++++++++++
 tb/tb_key_event_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared types and default timing for the key event decoder.
// 50 MHz defaults: 1 s long press, 300 ms double-click gap, 200 ms repeat.
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } key_state_e;

    localparam int CNT_W_DEF      = 26;
    localparam int LONG_CYC_DEF   = 50_000_000;
    localparam int DBL_CYC_DEF    = 15_000_000;
    localparam int REPEAT_CYC_DEF = 10_000_000;

endpackage

// File: rtl/key_edge_det.sv
// Registers an active-low key level and flags its press/release edges.
// Reset value is released (1), so a key held low out of reset reads as a press.
module key_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_r_o,
    output logic fall_o,
    output logic rise_o
);

    logic key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key_i;
        end
    end

    assign key_r_o = key_q;
    assign fall_o  = key_q & ~key_i;
    assign rise_o  = ~key_q & key_i;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short, long, repeat and double
// click events, each reported as a registered single-cycle pulse.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LONG_CYC   = LONG_CYC_DEF,
    parameter int DBL_CYC    = DBL_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic short_p,
    output logic long_p,
    output logic repeat_p,
    output logic double_p,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic key_r;
    logic fall;
    logic rise;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_clr;

    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic double_q, double_d;

    key_edge_det u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (key_n),
        .key_r_o (key_r),
        .fall_o  (fall),
        .rise_o  (rise)
    );

    // Saturate rather than wrap so a stuck key never re-triggers thresholds.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = PRESS1;
                end
            end
            PRESS1: begin
                if (rise) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HOLD;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            LONG_HOLD: begin
                if (rise) begin
                    state_d = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cnt_d = (cnt_clr || (state_d != state_q)) ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            double_q <= double_d;
        end
    end

    assign short_p  = short_q;
    assign long_p   = long_q;
    assign repeat_p = repeat_q;
    assign double_p = double_q;
    assign key_held = ~key_r;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with shortened timing.
module tb_key_event_decoder;

    localparam int LC = 20;
    localparam int DC = 8;
    localparam int RC = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_n = 1'b1;
    logic short_p;
    logic long_p;
    logic repeat_p;
    logic double_p;
    logic key_held;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int base = 0;
    int excl = 0;
    int n_s, n_l, n_r, n_d, n_h;
    int f_s, l_s, f_l, f_r, l_r, f_d, f_h;

    always #5 clk = ~clk;

    key_event_decoder #(
        .CNT_W      (26),
        .LONG_CYC   (LC),
        .DBL_CYC    (DC),
        .REPEAT_CYC (RC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .short_p  (short_p),
        .long_p   (long_p),
        .repeat_p (repeat_p),
        .double_p (double_p),
        .key_held (key_held)
    );

    task automatic clr();
        n_s = 0; n_l = 0; n_r = 0; n_d = 0; n_h = 0;
        f_s = -1; l_s = -1; f_l = -1;
        f_r = -1; l_r = -1; f_d = -1; f_h = -1;
        base = cyc;
    endtask

    task automatic tick();
        int t;
        @(posedge clk);
        #1;
        cyc++;
        t = cyc - base;
        if (short_p) begin
            n_s++;
            if (f_s < 0) f_s = t;
            l_s = t;
        end
        if (long_p) begin
            n_l++;
            if (f_l < 0) f_l = t;
        end
        if (repeat_p) begin
            n_r++;
            if (f_r < 0) f_r = t;
            l_r = t;
        end
        if (double_p) begin
            n_d++;
            if (f_d < 0) f_d = t;
        end
        if (key_held) begin
            n_h++;
            if (f_h < 0) f_h = t;
        end
        if (int'(short_p) + int'(long_p) + int'(repeat_p)
            + int'(double_p) > 1) excl++;
    endtask

    task automatic run(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        clr();
        #12;
        chk("rst_short", int'(short_p), 0);
        chk("rst_long", int'(long_p), 0);
        chk("rst_repeat", int'(repeat_p), 0);
        chk("rst_double", int'(double_p), 0);
        chk("rst_held", int'(key_held), 0);
        rst_n = 1'b1;
        run(1'b1, 3);

        // short press
        clr();
        run(1'b0, 5);
        run(1'b1, 15);
        chk("short_cnt", n_s, 1);
        chk("short_cyc", f_s, 14);
        chk("short_other", n_l + n_r + n_d, 0);
        chk("held_len", n_h, 5);
        chk("held_first", f_h, 1);

        // double click
        clr();
        run(1'b0, 4);
        run(1'b1, 3);
        run(1'b0, 4);
        run(1'b1, 15);
        chk("dbl_cnt", n_d, 1);
        chk("dbl_cyc", f_d, 12);
        chk("dbl_noshort", n_s, 0);

        // long press with repeat
        clr();
        run(1'b0, 32);
        run(1'b1, 15);
        chk("long_cnt", n_l, 1);
        chk("long_cyc", f_l, 21);
        chk("rep_cnt", n_r, 2);
        chk("rep_first", f_r, 26);
        chk("rep_last", l_r, 31);
        chk("long_other", n_s + n_d, 0);

        // release on the long threshold cycle
        clr();
        run(1'b0, 20);
        run(1'b1, 15);
        chk("b1_nolong", n_l, 0);
        chk("b1_short", n_s, 1);
        chk("b1_short_cyc", f_s, 29);

        // second press on the double-click timeout cycle
        clr();
        run(1'b0, 4);
        run(1'b1, 8);
        run(1'b0, 4);
        run(1'b1, 15);
        chk("b2_dbl", n_d, 1);
        chk("b2_dbl_cyc", f_d, 17);
        chk("b2_noshort", n_s, 0);

        // gap too long for a double click
        clr();
        run(1'b0, 4);
        run(1'b1, 10);
        run(1'b0, 4);
        run(1'b1, 15);
        chk("gap_short", n_s, 2);
        chk("gap_first", f_s, 13);
        chk("gap_last", l_s, 27);
        chk("gap_nodbl", n_d, 0);

        // reset during WAIT2 drops the gesture
        clr();
        run(1'b0, 4);
        run(1'b1, 3);
        #2;
        rst_n = 1'b0;
        #2;
        chk("rw_short", int'(short_p), 0);
        chk("rw_held", int'(key_held), 0);
        rst_n = 1'b1;
        run(1'b1, 15);
        chk("rw_noshort", n_s, 0);

        // reset on a long_p pulse, key held across release
        clr();
        run(1'b0, 21);
        chk("rl_long_pre", int'(long_p), 1);
        chk("rl_held_pre", int'(key_held), 1);
        rst_n = 1'b0;
        #2;
        chk("rl_long_rst", int'(long_p), 0);
        chk("rl_held_rst", int'(key_held), 0);
        rst_n = 1'b1;
        clr();
        run(1'b0, 25);
        chk("rl_long_cnt", n_l, 1);
        chk("rl_long_cyc", f_l, 21);
        run(1'b1, 10);

        chk("exclusive", excl, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
